// File: rtl/ecm_pkg.sv
// Shared constants and types for the ECM packet buffer/scheduler.
package ecm_pkg;

   localparam logic [11:0] ADDR_ECM_PKT_DATA  = 12'h102;
   localparam logic [11:0] ADDR_ECM_PID_INDEX = 12'h103;
   localparam logic [11:0] ADDR_ECM_TX_PERIOD = 12'h104;

   localparam int unsigned TICK_CYCLES_DEF = 270000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2
   } ecm_state_t;

   typedef struct packed {
      logic        vld;
      logic        sop;
      logic        eop;
      logic [15:0] dat;
   } ecm_word_t;

endpackage

// File: rtl/ecm_buf_ram.sv
// Two-bank ECM packet RAM: one write port, one registered read port; bank is the address MSB.
// Read latency 1 cycle; no flow control, contents undefined after reset.
module ecm_buf_ram #(
   parameter int DEPTH = 128,
   parameter int AW    = $clog2(2 * DEPTH)
) (
   input  logic          clk_27m,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [15:0]   wr_dat,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [15:0]   rd_dat
);

   logic [15:0] mem [2 * DEPTH];

   always_ff @(posedge clk_27m) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
      if (rd_en) begin
         rd_dat <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/ecm_pkt_sched.sv
// ECM packet capture (shadow bank) and periodic replay (active bank) as a 16-bit word stream.
// Start latency 2 cycles after IDLE sees a pending transmit; words hold while ecm_ready is low.
module ecm_pkt_sched
   import ecm_pkg::*;
#(
   parameter int BUF_DEPTH   = 128,
   parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
   input  logic        clk_27m,
   input  logic        rst_n,
   input  logic        cfg_wr,
   input  logic [11:0] cfg_addr,
   input  logic [15:0] cfg_wdata,
   output logic [15:0] ecm_pid_index,
   output logic [15:0] ecm_data,
   output logic        ecm_valid,
   output logic        ecm_sop,
   output logic        ecm_eop,
   input  logic        ecm_ready,
   output logic        ecm_ovf
);

   localparam int IW = $clog2(BUF_DEPTH);
   localparam int TW = $clog2(TICK_CYCLES + 1);
   localparam logic [IW:0]   DEPTH_L   = (IW+1)'(BUF_DEPTH);
   localparam logic [IW:0]   LEN_ONE   = {{IW{1'b0}}, 1'b1};
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

   ecm_state_t  state_q, state_d;
   ecm_word_t   out_q;

   logic [IW:0]   wr_cnt, shadow_len, act_len, out_idx, rd_ptr, rd_idx;
   logic          act_bank, swap_pend, tx_pend;
   logic [15:0]   period, per_cnt;
   logic [TW-1:0] tick_cnt;
   logic [15:0]   rd_dat;

   logic wr_data, wr_pid, wr_commit, data_room, tick, per_hit;
   logic rd_en, do_swap, tx_take, ld_first, advance, finish;

   assign wr_data   = cfg_wr && (cfg_addr == ADDR_ECM_PKT_DATA);
   assign wr_pid    = cfg_wr && (cfg_addr == ADDR_ECM_PID_INDEX);
   assign wr_commit = cfg_wr && (cfg_addr == ADDR_ECM_TX_PERIOD);
   assign data_room = (wr_cnt < DEPTH_L);

   assign tick    = (tick_cnt == TICK_LAST);
   assign per_hit = tick && (period != 16'd0) && (per_cnt + 16'd1 == period);

   assign ecm_data  = out_q.dat;
   assign ecm_valid = out_q.vld;
   assign ecm_sop   = out_q.sop;
   assign ecm_eop   = out_q.eop;

   ecm_buf_ram #(
      .DEPTH (BUF_DEPTH),
      .AW    (IW + 1)
   ) u_ram (
      .clk_27m (clk_27m),
      .wr_en   (wr_data && data_room),
      .wr_addr ({~act_bank, wr_cnt[IW-1:0]}),
      .wr_dat  (cfg_wdata),
      .rd_en   (rd_en),
      .rd_addr ({act_bank, rd_idx[IW-1:0]}),
      .rd_dat  (rd_dat)
   );

   always_ff @(posedge clk_27m or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rd_en    = 1'b0;
      rd_idx   = rd_ptr;
      do_swap  = 1'b0;
      tx_take  = 1'b0;
      ld_first = 1'b0;
      advance  = 1'b0;
      finish   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (swap_pend) begin
               do_swap = 1'b1;
            end else if (tx_pend) begin
               tx_take = 1'b1;
               if (act_len != '0) begin
                  rd_en   = 1'b1;
                  rd_idx  = '0;
                  state_d = ST_FETCH;
               end
            end
         end
         ST_FETCH: begin
            // word 0 lands in the output register while word 1 is prefetched
            ld_first = 1'b1;
            rd_en    = 1'b1;
            state_d  = ST_SEND;
         end
         ST_SEND: begin
            if (out_q.vld && ecm_ready) begin
               if (out_q.eop) begin
                  finish  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  advance = 1'b1;
                  rd_en   = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Shadow-side capture and commit; commit wins over a same-cycle swap clearing swap_pend.
   always_ff @(posedge clk_27m or negedge rst_n) begin
      if (!rst_n) begin
         ecm_pid_index <= '0;
         wr_cnt        <= '0;
         shadow_len    <= '0;
         act_len       <= '0;
         period        <= '0;
         act_bank      <= 1'b0;
         swap_pend     <= 1'b0;
         ecm_ovf       <= 1'b0;
      end else begin
         if (wr_pid) begin
            ecm_pid_index <= cfg_wdata;
         end
         if (do_swap) begin
            act_bank  <= ~act_bank;
            act_len   <= shadow_len;
            swap_pend <= 1'b0;
         end
         if (wr_commit) begin
            period     <= cfg_wdata;
            shadow_len <= wr_cnt;
            swap_pend  <= 1'b1;
            ecm_ovf    <= 1'b0;
            wr_cnt     <= '0;
         end else if (wr_data) begin
            if (data_room) begin
               wr_cnt <= wr_cnt + 1'b1;
            end else begin
               ecm_ovf <= 1'b1;
            end
         end
      end
   end

   // A swap restarts the schedule, so a transmit request from the old timing is dropped.
   always_ff @(posedge clk_27m or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
         per_cnt  <= '0;
         tx_pend  <= 1'b0;
      end else if (do_swap) begin
         tick_cnt <= '0;
         per_cnt  <= '0;
         tx_pend  <= 1'b0;
      end else begin
         if (tx_take) begin
            tx_pend <= 1'b0;
         end
         if (tick) begin
            tick_cnt <= '0;
            if (per_hit) begin
               per_cnt <= '0;
               tx_pend <= 1'b1;
            end else begin
               per_cnt <= per_cnt + 16'd1;
            end
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_27m or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         out_idx <= '0;
         rd_ptr  <= '0;
      end else begin
         if (rd_en) begin
            rd_ptr <= rd_idx + 1'b1;
         end
         if (ld_first) begin
            out_q.vld <= 1'b1;
            out_q.sop <= 1'b1;
            out_q.eop <= (act_len == LEN_ONE);
            out_q.dat <= rd_dat;
            out_idx   <= '0;
         end else if (advance) begin
            out_q.sop <= 1'b0;
            out_q.eop <= (out_idx + 1'b1 == act_len - 1'b1);
            out_q.dat <= rd_dat;
            out_idx   <= out_idx + 1'b1;
         end else if (finish) begin
            out_q.vld <= 1'b0;
            out_q.sop <= 1'b0;
            out_q.eop <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ecm_pkt_sched.sv
// Bench for ecm_pkt_sched: queue-based packet model, packet-level stream capture and schedule timing.
module tb_ecm_pkt_sched;
   import ecm_pkg::*;

   localparam int DEPTH = 128;
   localparam int TICK  = 100;

   logic        clk_27m = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_wr = 1'b0;
   logic [11:0] cfg_addr = '0;
   logic [15:0] cfg_wdata = '0;
   logic [15:0] ecm_pid_index;
   logic [15:0] ecm_data;
   logic        ecm_valid, ecm_sop, ecm_eop, ecm_ovf;
   logic        ecm_ready = 1'b1;

   ecm_pkt_sched #(.BUF_DEPTH(DEPTH), .TICK_CYCLES(TICK)) dut (
      .clk_27m       (clk_27m),
      .rst_n         (rst_n),
      .cfg_wr        (cfg_wr),
      .cfg_addr      (cfg_addr),
      .cfg_wdata     (cfg_wdata),
      .ecm_pid_index (ecm_pid_index),
      .ecm_data      (ecm_data),
      .ecm_valid     (ecm_valid),
      .ecm_sop       (ecm_sop),
      .ecm_eop       (ecm_eop),
      .ecm_ready     (ecm_ready),
      .ecm_ovf       (ecm_ovf)
   );

   always #5 clk_27m = ~clk_27m;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit bp_mode = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // captured packets, stored flat
   logic [15:0] rx_data[$];
   int rx_start[$], rx_len[$], rx_sop_cyc[$], rx_eop_cyc[$];
   int cur_start, cur_cyc, n_vld = 0, proto_err = 0;
   bit in_pkt = 1'b0, prev_stall = 1'b0;
   logic [18:0] prev_word;

   // model state: words written since the last commit, and the committed packet
   logic [15:0] shadow_q[$];
   logic [15:0] commit_q[$];
   bit          m_ovf = 1'b0;
   int          commit_cyc = 0;

   initial forever begin
      @(posedge clk_27m);
      cyc++;
   end

   initial forever begin
      @(posedge clk_27m);
      #1;
      ecm_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   initial forever begin
      @(negedge clk_27m);
      if (!rst_n) begin
         in_pkt     = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            check_eq("stall_hold", 32'({ecm_valid, ecm_sop, ecm_eop, ecm_data}), 32'(prev_word));
         if (ecm_valid) n_vld++;
         if (ecm_valid && ecm_ready) begin
            if (ecm_sop) begin
               if (in_pkt) proto_err++;
               in_pkt    = 1'b1;
               cur_start = rx_data.size();
               cur_cyc   = cyc;
            end else if (!in_pkt) begin
               proto_err++;
            end
            rx_data.push_back(ecm_data);
            if (ecm_eop && in_pkt) begin
               rx_start.push_back(cur_start);
               rx_len.push_back(rx_data.size() - cur_start);
               rx_sop_cyc.push_back(cur_cyc);
               rx_eop_cyc.push_back(cyc);
               in_pkt = 1'b0;
            end
         end
         prev_stall = ecm_valid && !ecm_ready;
         prev_word  = {ecm_valid, ecm_sop, ecm_eop, ecm_data};
      end
   end

   // Swap happens the first IDLE cycle after ref; then period*TICK cycles, then pend flag, read, output register.
   function automatic int first_sop(input int ref_cyc, input int per);
      return ref_cyc + 1 + per * TICK + 3;
   endfunction

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk_27m);
         #1;
      end
   endtask

   task automatic cfg_write(input logic [11:0] a, input logic [15:0] d);
      if (a == ADDR_ECM_TX_PERIOD) commit_cyc = cyc;
      cfg_wr    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      @(posedge clk_27m);
      #1;
      cfg_wr = 1'b0;
      if (a == ADDR_ECM_PKT_DATA) begin
         if (shadow_q.size() < DEPTH) shadow_q.push_back(d);
         else m_ovf = 1'b1;
      end else if (a == ADDR_ECM_TX_PERIOD) begin
         commit_q = shadow_q;
         shadow_q.delete();
         m_ovf = 1'b0;
      end
   endtask

   task automatic wait_pkts(input string tag, input int n, input int budget);
      for (int i = 0; i < budget && rx_len.size() < n; i++) run(1);
      check_eq(tag, 32'(rx_len.size() >= n), 1);
   endtask

   task automatic check_pkt(input string tag, input int k, input logic [15:0] exp[$]);
      int nd;
      if (k >= rx_len.size()) begin
         check_eq({tag, "_missing"}, rx_len.size(), k + 1);
         return;
      end
      check_eq({tag, "_len"}, rx_len[k], exp.size());
      nd = 0;
      for (int i = 0; i < exp.size(); i++)
         if (i >= rx_len[k] || rx_data[rx_start[k] + i] !== exp[i]) nd++;
      check_eq({tag, "_data"}, nd, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_valid"}, 32'(ecm_valid), 0);
      check_eq({tag, "_sop"},   32'(ecm_sop), 0);
      check_eq({tag, "_eop"},   32'(ecm_eop), 0);
      check_eq({tag, "_data"},  32'(ecm_data), 0);
      check_eq({tag, "_ovf"},   32'(ecm_ovf), 0);
      check_eq({tag, "_pid"},   32'(ecm_pid_index), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] nom[$];
      logic [15:0] pa[$];
      logic [15:0] pb[$];
      int base, tc, len, snap_p, snap_v;
      bit found;

      // reset and quiet start
      run(3);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      run(10000);
      check_eq("idle_no_valid", n_vld, 0);
      check_eq("idle_no_pkt", rx_len.size(), 0);

      // nominal packet
      nom = {16'h8001, 16'h0030, 16'h00bc, 16'h4701};
      for (int i = 0; i <= 92; i++) nom.push_back(16'(i));
      nom.push_back(16'haaaa);
      foreach (nom[i]) cfg_write(ADDR_ECM_PKT_DATA, nom[i]);
      cfg_write(ADDR_ECM_PID_INDEX, 16'h03ff);
      check_eq("pid", 32'(ecm_pid_index), 32'h03ff);
      cfg_write(ADDR_ECM_TX_PERIOD, 16'd2);
      tc   = commit_cyc;
      base = rx_len.size();
      wait_pkts("nom_wait", base + 3, 1200);
      check_pkt("nom0", base, nom);
      check_pkt("nom2", base + 2, nom);
      if (rx_len.size() >= base + 3) begin
         check_eq("nom_first_sop", rx_sop_cyc[base], first_sop(tc, 2));
         check_eq("nom_period1", rx_sop_cyc[base + 1] - rx_sop_cyc[base], 2 * TICK);
         check_eq("nom_period2", rx_sop_cyc[base + 2] - rx_sop_cyc[base + 1], 2 * TICK);
         check_eq("nom_contig", rx_eop_cyc[base] - rx_sop_cyc[base], nom.size() - 1);
      end

      // same packet under random backpressure
      bp_mode = 1'b1;
      base = rx_len.size();
      wait_pkts("bp_wait", base + 3, 3000);
      for (int k = 0; k < 3; k++) check_pkt($sformatf("bp%0d", k), base + k, nom);

      // random packets, including the single-word case
      for (int it = 0; it < 4; it++) begin
         bp_mode = 1'($urandom_range(0, 1));
         len = (it == 0) ? 1 : int'($urandom_range(2, 40));
         for (int i = 0; i < len; i++) cfg_write(ADDR_ECM_PKT_DATA, 16'($urandom));
         cfg_write(ADDR_ECM_TX_PERIOD, 16'd1);
         base = rx_len.size();
         wait_pkts($sformatf("rnd%0d_wait", it), base + 3, 2500);
         check_pkt($sformatf("rnd%0d_a", it), base + 1, commit_q);
         check_pkt($sformatf("rnd%0d_b", it), base + 2, commit_q);
         if (!bp_mode && rx_len.size() >= base + 3)
            check_eq($sformatf("rnd%0d_period", it), rx_sop_cyc[base + 2] - rx_sop_cyc[base + 1], TICK);
      end
      bp_mode = 1'b0;
      run(2);

      // overflow
      for (int i = 0; i < 130; i++) begin
         cfg_write(ADDR_ECM_PKT_DATA, 16'($urandom));
         if (i == 127) check_eq("ovf_after_128", 32'(ecm_ovf), 32'(m_ovf));
         if (i == 128) check_eq("ovf_after_129", 32'(ecm_ovf), 32'(m_ovf));
      end
      check_eq("ovf_model_set", 32'(m_ovf), 1);
      cfg_write(ADDR_ECM_TX_PERIOD, 16'd1);
      check_eq("ovf_cleared", 32'(ecm_ovf), 0);
      base = rx_len.size();
      wait_pkts("ovf_wait", base + 3, 2000);
      check_pkt("ovf_a", base + 1, commit_q);
      check_pkt("ovf_b", base + 2, commit_q);

      // commit while packet A is in flight
      for (int i = 0; i < 98; i++) cfg_write(ADDR_ECM_PKT_DATA, 16'($urandom));
      cfg_write(ADDR_ECM_TX_PERIOD, 16'd2);
      pa   = commit_q;
      base = rx_len.size();
      wait_pkts("mid_a_wait", base + 2, 2000);
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         run(1);
         if (ecm_valid && ecm_sop) found = 1'b1;
      end
      check_eq("mid_a_started", 32'(found), 1);
      run(10);
      base = rx_len.size();
      for (int i = 0; i < 4; i++) cfg_write(ADDR_ECM_PKT_DATA, 16'($urandom));
      cfg_write(ADDR_ECM_TX_PERIOD, 16'd2);
      pb = commit_q;
      wait_pkts("mid_b_wait", base + 3, 2000);
      check_pkt("mid_a", base, pa);
      check_pkt("mid_b0", base + 1, pb);
      check_pkt("mid_b1", base + 2, pb);
      if (rx_len.size() >= base + 3)
         check_eq("mid_b_start", rx_sop_cyc[base + 1], first_sop(rx_eop_cyc[base], 2));

      // period 0 disables transmission
      for (int i = 0; i < 5; i++) cfg_write(ADDR_ECM_PKT_DATA, 16'($urandom));
      cfg_write(ADDR_ECM_TX_PERIOD, 16'd0);
      run(20);
      snap_p = rx_len.size();
      snap_v = n_vld;
      run(1000);
      check_eq("dis_no_pkt", rx_len.size(), snap_p);
      check_eq("dis_no_valid", n_vld, snap_v);

      // reset mid-packet
      for (int i = 0; i < 5; i++) cfg_write(ADDR_ECM_PKT_DATA, 16'($urandom));
      cfg_write(ADDR_ECM_TX_PERIOD, 16'd1);
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         run(1);
         if (ecm_valid && !ecm_sop) found = 1'b1;
      end
      check_eq("rst_midpkt_seen", 32'(found), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      run(3);
      rst_n  = 1'b1;
      snap_p = rx_len.size();
      snap_v = n_vld;
      run(1000);
      check_eq("rst_no_pkt", rx_len.size(), snap_p);
      check_eq("rst_no_valid", n_vld, snap_v);
      check_eq("proto", proto_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
